wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: CNT_W, default 32, width of the committed-write counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-004 reg_write  input  1  write-back enable from the MEM/WB stage register.
REQ-005 memtoreg  input  1  write-back source select: 1 = read_data, 0 = ALU_result.
REQ-006 rd  input  5  destination register index.
REQ-007 ALU_result  input  64  ALU result from MEM/WB.
REQ-008 read_data  input  64  data-memory load result from MEM/WB.
REQ-009 rs1  input  5  read port 1 register index (decode stage).
REQ-010 rs2  input  5  read port 2 register index (decode stage).
REQ-011 readdata1  output  64  register value for rs1.
REQ-012 readdata2  output  64  register value for rs2.
REQ-013 wb_data  output  64  selected write-back value, combinational.
REQ-014 wb_count  output  CNT_W  number of committed register writes since reset.

Function
REQ-015 wb_data SHALL equal read_data when memtoreg=1, else ALU_result, with zero latency.
REQ-016 Storage SHALL be 32 x 64-bit registers x0..x31.
REQ-017 A write SHALL commit on the rising clk edge when reset=1, reg_write=1 and rd!=0: x[rd] <= wb_data.
REQ-018 A write with rd=0 SHALL be discarded; x0 SHALL read 0 at all times.
REQ-019 readdata1/readdata2 SHALL be combinational reads of x[rs1]/x[rs2]; index 0 returns 0.
REQ-020 rs1==rs2 SHALL return identical values on both ports.
REQ-021 wb_count SHALL increment by 1 on each committed write (REQ-017 only); rd=0 or reg_write=0 SHALL NOT count.
REQ-022 wb_count SHALL wrap from 2^CNT_W-1 to 0 with no flag or saturation.
REQ-023 With reg_write=0, register contents and wb_count SHALL hold; memtoreg, ALU_result and read_data are don't-care for state.
REQ-024 Back-to-back writes to the same rd on consecutive cycles SHALL each commit; the last one wins.

Reset
REQ-025 reset=0 SHALL immediately, independent of clk, clear x1..x31 and wb_count to 0.
REQ-026 While reset=0, readdata1/readdata2 SHALL read 0 and no write SHALL commit.
REQ-027 reset asserted mid-stream SHALL discard any write presented in that cycle; after deassertion the first rising edge with a valid write SHALL commit it normally.
REQ-028 wb_data SHALL remain a pure function of its inputs during reset.

Configuration
REQ-029 Macro WB_BYPASS_EN: when defined, if reg_write=1, rd!=0, reset=1 and rsN==rd, readdataN SHALL return wb_data in the same cycle (write-before-read).
REQ-030 When WB_BYPASS_EN is not defined, readdataN SHALL return the pre-edge stored value; the new value becomes visible the cycle after the commit edge.

Verification
REQ-031 reset=0 pulse, then rs1=5, rs2=31 -> readdata1=0, readdata2=0, wb_count=0.
REQ-032 reg_write=1, memtoreg=0, rd=3, ALU_result=64'h1234_5678_9ABC_DEF0, one edge; then rs1=3 -> readdata1=64'h1234_5678_9ABC_DEF0, wb_count=1.
REQ-033 reg_write=1, memtoreg=1, rd=0, read_data=64'hFFFF_FFFF_FFFF_FFFF, one edge; rs1=0 -> readdata1=0, wb_count unchanged.
REQ-034 rd=7, rs2=7, reg_write=1, memtoreg=1, read_data=64'hA5 in same cycle -> readdata2=64'hA5 before edge with WB_BYPASS_EN, old x7 without.
REQ-035 Preload wb_count to 2^CNT_W-1 (CNT_W=4 build, 15 commits), one more commit to rd=1 -> wb_count=0.
REQ-036 Write x9=64'h55, then assert reset=0 between edges with reg_write=1, rd=9, ALU_result=64'hAA -> readdata1 (rs1=9)=0 immediately; after release x9 stays 0 until a new commit.

Source files
------------

// File: rtl/wb_regfile.sv
// 32 x 64-bit write-back register file with combinational read ports and a committed-write counter.
// Optional macro WB_BYPASS_EN forwards same-cycle write-back data to matching read ports.
module wb_regfile #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_write,
  input  logic             memtoreg,
  input  logic [4:0]       rd,
  input  logic [63:0]      ALU_result,
  input  logic [63:0]      read_data,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic [63:0]      readdata1,
  output logic [63:0]      readdata2,
  output logic [63:0]      wb_data,
  output logic [CNT_W-1:0] wb_count
);

  logic [63:0] regs [0:31];
  logic        commit;

  assign wb_data = memtoreg ? read_data : ALU_result;
  assign commit  = reg_write && (rd != 5'd0);

  // x0 is cleared by reset and never written, so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      wb_count <= '0;
    end else if (commit) begin
      regs[rd] <= wb_data;
      wb_count <= wb_count + CNT_W'(1);
    end
  end

  always_comb begin
    readdata1 = '0;
    readdata2 = '0;
    if (reset && rs1 != 5'd0) readdata1 = regs[rs1];
    if (reset && rs2 != 5'd0) readdata2 = regs[rs2];
`ifdef WB_BYPASS_EN
    if (reset && commit && rs1 == rd) readdata1 = wb_data;
    if (reset && commit && rs2 == rd) readdata2 = wb_data;
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: array model checked every falling edge plus directed literal checks.
module tb_wb_regfile;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             reg_write = 1'b0;
  logic             memtoreg = 1'b0;
  logic [4:0]       rd = '0;
  logic [63:0]      ALU_result = '0;
  logic [63:0]      read_data = '0;
  logic [4:0]       rs1 = '0;
  logic [4:0]       rs2 = '0;
  logic [63:0]      readdata1;
  logic [63:0]      readdata2;
  logic [63:0]      wb_data;
  logic [CNT_W-1:0] wb_count;

  int errors = 0;
  int checks = 0;

  wb_regfile #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .memtoreg(memtoreg),
    .rd(rd), .ALU_result(ALU_result), .read_data(read_data),
    .rs1(rs1), .rs2(rs2), .readdata1(readdata1), .readdata2(readdata2),
    .wb_data(wb_data), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  // Reference model: plain array of register values and an integer commit count.
  logic [63:0] model [32];
  int          mcount = 0;

  initial for (int i = 0; i < 32; i++) model[i] = '0;

  function automatic logic [63:0] exp_wb();
    return memtoreg ? read_data : ALU_result;
  endfunction

  function automatic logic [63:0] exp_read(input logic [4:0] rs);
    if (!reset || rs == 5'd0) return '0;
`ifdef WB_BYPASS_EN
    if (reg_write && rd != 5'd0 && rs == rd) return exp_wb();
`endif
    return model[rs];
  endfunction

  always @(negedge reset) begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    mcount = 0;
  end

  always @(posedge clk) begin
    if (reset && reg_write && rd != 5'd0) begin
      model[rd] = exp_wb();
      mcount = (mcount + 1) % (1 << CNT_W);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_wb_data", wb_data, exp_wb());
      check("model_readdata1", readdata1, exp_read(rs1));
      check("model_readdata2", readdata2, exp_read(rs2));
      check("model_wb_count", 64'(wb_count), 64'(mcount));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] r, input logic [63:0] v, input logic m);
    reg_write = 1'b1;
    rd = r;
    memtoreg = m;
    if (m) read_data = v; else ALU_result = v;
    step();
    reg_write = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1;
    check("reset_rd1", readdata1, 64'h0);
    check("reset_count", 64'(wb_count), 64'h0);
    step();
    reset = 1'b1;
    cmp_en = 1'b1;

    rs1 = 5'd5; rs2 = 5'd31;
    sample();
    check("r031_rd1", readdata1, 64'h0);
    check("r031_rd2", readdata2, 64'h0);
    check("r031_count", 64'(wb_count), 64'h0);
    step();

    wr(5'd3, 64'h1234_5678_9ABC_DEF0, 1'b0);
    rs1 = 5'd3;
    sample();
    check("r032_rd1", readdata1, 64'h1234_5678_9ABC_DEF0);
    check("r032_count", 64'(wb_count), 64'd1);
    step();

    wr(5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    rs1 = 5'd0;
    sample();
    check("r033_rd1", readdata1, 64'h0);
    check("r033_count", 64'(wb_count), 64'd1);
    check("r033_wbdata", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
    step();

    wr(5'd7, 64'h11, 1'b0);
    rs2 = 5'd7;
    reg_write = 1'b1; rd = 5'd7; memtoreg = 1'b1; read_data = 64'hA5;
    sample();
`ifdef WB_BYPASS_EN
    check("r034_bypass", readdata2, 64'hA5);
`else
    check("r034_old", readdata2, 64'h11);
`endif
    step();
    reg_write = 1'b0;
    sample();
    check("r034_after", readdata2, 64'hA5);
    check("r034_count", 64'(wb_count), 64'd3);
    step();

    // Consecutive writes to one register; the second value must remain.
    wr(5'd4, 64'h1, 1'b0);
    wr(5'd4, 64'h2, 1'b1);
    rs1 = 5'd4; rs2 = 5'd3;
    sample();
    check("b2b_last", readdata1, 64'h2);
    check("b2b_count", 64'(wb_count), 64'd5);
    step();

    // Idle cycles with garbage on the data inputs must not disturb state.
    for (int i = 0; i < 4; i++) begin
      memtoreg = i[0]; rd = 5'(i + 3);
      ALU_result = {$urandom, $urandom}; read_data = {$urandom, $urandom};
      step();
    end
    sample();
    check("hold_x3", readdata2, 64'h1234_5678_9ABC_DEF0);
    step();

    for (int i = 0; i < 10; i++) wr(5'(10 + i), 64'(i * 3 + 100), i[0]);
    sample();
    check("pre_wrap_count", 64'(wb_count), 64'd15);
    step();
    wr(5'd1, 64'hBEEF, 1'b0);
    rs1 = 5'd1;
    sample();
    check("wrap_count", 64'(wb_count), 64'd0);
    check("wrap_x1", readdata1, 64'hBEEF);
    step();

    wr(5'd9, 64'h55, 1'b0);
    rs1 = 5'd9;
    sample();
    check("r036_pre", readdata1, 64'h55);
    step();
    reg_write = 1'b1; rd = 5'd9; memtoreg = 1'b0; ALU_result = 64'hAA;
    #1 reset = 1'b0;
    #1;
    check("r036_immediate", readdata1, 64'h0);
    check("r036_count", 64'(wb_count), 64'h0);
    check("r036_wbdata", wb_data, 64'hAA);
    step();
    reset = 1'b1;
    reg_write = 1'b0;
    sample();
    check("r036_after_rel", readdata1, 64'h0);
    step();
    wr(5'd9, 64'h77, 1'b0);
    sample();
    check("r036_new_commit", readdata1, 64'h77);
    check("r036_new_count", 64'(wb_count), 64'd1);
    step();

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
